// File: rtl/game_ctrl.sv
// Two-lane rhythm game controller: IDLE/PLAY/OVER sequencing, hit and miss
// detection against the note shifter, score and lives bookkeeping.
module game_ctrl #(
  parameter int LIVES_INIT  = 3,
  parameter int SONG_CYCLES = 1024,
  parameter int SCORE_W     = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               BTN1,
  input  logic               BTN2,
  input  logic [15:0]        LINE1,
  input  logic [15:0]        LINE2,
  input  logic [15:0]        PNTS1,
  input  logic [15:0]        PNTS2,
  output logic               SHIFT_RST,
  output logic [SCORE_W-1:0] SCORE,
  output logic [1:0]         LIVES,
  output logic [1:0]         GSTATE,
  output logic               HIT1,
  output logic               HIT2,
  output logic               MISS,
  output logic               WIN
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_PLAY = 2'b01;
  localparam logic [1:0] S_OVER = 2'b10;

  localparam int               CNT_W      = (SONG_CYCLES > 1) ? $clog2(SONG_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SONG_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [1:0]       LIVES_LOAD = 2'(LIVES_INIT);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             start_q, btn1_q, btn2_q;
  logic [15:0]      line1_q, line2_q;
  logic             used1, used2;

  logic             playing;
  logic             start_edge, btn1_edge, btn2_edge;
  logic             shift1, shift2;
  logic             used1_eff, used2_eff;
  logic             hit1, hit2, miss1, miss2;
  logic [2:0]       gain1, gain2;
  logic [SCORE_W:0] score_sum;
  logic [SCORE_W-1:0] score_next;
  logic [1:0]       miss_cnt;
  logic [1:0]       lives_next;
  logic             unused_pnts;

  assign playing    = (state == S_PLAY);
  assign start_edge = START & ~start_q;
  assign btn1_edge  = BTN1 & ~btn1_q;
  assign btn2_edge  = BTN2 & ~btn2_q;

  // A note in the hit zone is claimable again as soon as the lane moves.
  assign shift1    = (LINE1 != line1_q);
  assign shift2    = (LINE2 != line2_q);
  assign used1_eff = used1 & ~shift1;
  assign used2_eff = used2 & ~shift2;

  assign hit1  = playing & btn1_edge & LINE1[0] & ~used1_eff;
  assign hit2  = playing & btn2_edge & LINE2[0] & ~used2_eff;
  assign miss1 = playing & shift1 & line1_q[0] & ~used1;
  assign miss2 = playing & shift2 & line2_q[0] & ~used2;

  assign gain1 = hit1 ? (PNTS1[0] ? 3'd3 : 3'd1) : 3'd0;
  assign gain2 = hit2 ? (PNTS2[0] ? 3'd3 : 3'd1) : 3'd0;

  assign score_sum  = {1'b0, SCORE} + (SCORE_W+1)'(gain1) + (SCORE_W+1)'(gain2);
  assign score_next = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];

  assign miss_cnt   = {1'b0, miss1} + {1'b0, miss2};
  assign lives_next = (LIVES > miss_cnt) ? (LIVES - miss_cnt) : 2'd0;

  assign unused_pnts = ^{PNTS1[15:1], PNTS2[15:1]};

  // Button copies reset high so a button held through reset release is not an edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      SCORE     <= '0;
      LIVES     <= LIVES_LOAD;
      WIN       <= 1'b0;
      SHIFT_RST <= 1'b1;
      start_q   <= 1'b1;
      btn1_q    <= 1'b1;
      btn2_q    <= 1'b1;
      line1_q   <= '0;
      line2_q   <= '0;
      used1     <= 1'b0;
      used2     <= 1'b0;
    end else begin
      start_q   <= START;
      btn1_q    <= BTN1;
      btn2_q    <= BTN2;
      line1_q   <= LINE1;
      line2_q   <= LINE2;
      used1     <= hit1 | used1_eff;
      used2     <= hit2 | used2_eff;
      SHIFT_RST <= (state != S_PLAY);

      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state <= S_PLAY;
            SCORE <= '0;
            LIVES <= LIVES_LOAD;
            cnt   <= '0;
            WIN   <= 1'b0;
          end
        end
        S_PLAY: begin
          SCORE <= score_next;
          LIVES <= lives_next;
          if (lives_next == 2'd0) begin
            state <= S_OVER;
            WIN   <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= S_OVER;
            WIN   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_OVER: begin
          if (start_edge) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign GSTATE = state;
  assign HIT1   = hit1;
  assign HIT2   = hit2;
  assign MISS   = miss1 | miss2;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: a hand-derived vector table, an abort-by-reset sequence,
// then randomized play checked against a rule-level model of the game.
module tb_game_ctrl;

  localparam int SONG = 8;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, btn1 = 1'b0, btn2 = 1'b0;
  logic [15:0]   line1 = '0, line2 = '0, pnts1 = '0, pnts2 = '0;
  logic          shift_rst;
  logic [SW-1:0] score;
  logic [1:0]    lives, gstate;
  logic          hit1, hit2, miss, win;

  int tests = 0;
  int fails = 0;

  game_ctrl #(.LIVES_INIT(3), .SONG_CYCLES(SONG), .SCORE_W(SW)) dut (
    .CLK(clk), .RST(rst_n), .START(start), .BTN1(btn1), .BTN2(btn2),
    .LINE1(line1), .LINE2(line2), .PNTS1(pnts1), .PNTS2(pnts2),
    .SHIFT_RST(shift_rst), .SCORE(score), .LIVES(lives), .GSTATE(gstate),
    .HIT1(hit1), .HIT2(hit2), .MISS(miss), .WIN(win)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, b1, b2;
    logic [15:0] l1, l2, p1, p2;
    int gs, sc, lv;
    logic h1, h2, ms, w, sr;
  } vec_t;

  vec_t tbl[$];

  // Rule-level model state: game phase, elapsed play cycles, claimed notes.
  int          m_state, m_score, m_lives, m_played;
  bit          m_win, m_srst, m_pst, m_pb1, m_pb2, m_used1, m_used2;
  logic [15:0] m_pl1, m_pl2;

  task automatic addVec(input logic st, b1, b2, input logic [15:0] l1, l2, p1, p2,
                        input int gs, sc, lv, input logic h1, h2, ms, w, sr);
    vec_t v;
    v.st = st; v.b1 = b1; v.b2 = b2;
    v.l1 = l1; v.l2 = l2; v.p1 = p1; v.p2 = p2;
    v.gs = gs; v.sc = sc; v.lv = lv;
    v.h1 = h1; v.h2 = h2; v.ms = ms; v.w = w; v.sr = sr;
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input logic st, b1, b2, input logic [15:0] l1, l2, p1, p2);
    @(posedge clk);
    #1;
    start = st; btn1 = b1; btn2 = b2;
    line1 = l1; line2 = l2; pnts1 = p1; pnts2 = p2;
  endtask

  task automatic checkOutput(input string what, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", what, got, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int idx, input int gs, sc, lv,
                          input logic h1, h2, ms, w, sr);
    checkOutput($sformatf("%s[%0d] gstate", tag, idx), 32'(gstate), gs);
    checkOutput($sformatf("%s[%0d] score", tag, idx), 32'(score), sc);
    checkOutput($sformatf("%s[%0d] lives", tag, idx), 32'(lives), lv);
    checkOutput($sformatf("%s[%0d] hit1", tag, idx), 32'(hit1), 32'(h1));
    checkOutput($sformatf("%s[%0d] hit2", tag, idx), 32'(hit2), 32'(h2));
    checkOutput($sformatf("%s[%0d] miss", tag, idx), 32'(miss), 32'(ms));
    checkOutput($sformatf("%s[%0d] win", tag, idx), 32'(win), 32'(w));
    checkOutput($sformatf("%s[%0d] shift_rst", tag, idx), 32'(shift_rst), 32'(sr));
  endtask

  task automatic modelReset();
    m_state = 0; m_score = 0; m_lives = 3; m_played = 0;
    m_win = 0; m_srst = 1;
    m_pst = 1; m_pb1 = 1; m_pb2 = 1;
    m_used1 = 0; m_used2 = 0;
    m_pl1 = '0; m_pl2 = '0;
  endtask

  task automatic modelStep(input string tag, input int idx);
    bit play, es, e1, e2, sh1, sh2, h1, h2, mi1, mi2;
    int pts, misses;
    play = (m_state == 1);
    es   = start && !m_pst;
    e1   = btn1 && !m_pb1;
    e2   = btn2 && !m_pb2;
    sh1  = (line1 != m_pl1);
    sh2  = (line2 != m_pl2);
    h1   = play && e1 && line1[0] && !(m_used1 && !sh1);
    h2   = play && e2 && line2[0] && !(m_used2 && !sh2);
    mi1  = play && sh1 && m_pl1[0] && !m_used1;
    mi2  = play && sh2 && m_pl2[0] && !m_used2;
    checkAll(tag, idx, m_state, m_score, m_lives, h1, h2, mi1 || mi2, m_win, m_srst);

    pts    = (h1 ? (pnts1[0] ? 3 : 1) : 0) + (h2 ? (pnts2[0] ? 3 : 1) : 0);
    misses = int'(mi1) + int'(mi2);
    m_srst  = (m_state != 1);
    m_used1 = h1 || (m_used1 && !sh1);
    m_used2 = h2 || (m_used2 && !sh2);
    case (m_state)
      0: if (es) begin
        m_state = 1; m_score = 0; m_lives = 3; m_played = 0; m_win = 0;
      end
      1: begin
        m_score  = (m_score + pts > SMAX) ? SMAX : m_score + pts;
        m_lives  = (m_lives - misses < 0) ? 0 : m_lives - misses;
        m_played = m_played + 1;
        if (m_lives == 0) begin
          m_state = 2; m_win = 0;
        end else if (m_played == SONG) begin
          m_state = 2; m_win = 1;
        end
      end
      default: if (es) m_state = 0;
    endcase
    m_pst = start; m_pb1 = btn1; m_pb2 = btn2;
    m_pl1 = line1; m_pl2 = line2;
  endtask

  initial begin
    logic [15:0] n1, n2, q1, q2;
    logic        ns, nb1, nb2;

    //     st b1 b2  l1      l2      p1 p2   gs sc lv  h1 h2 ms w sr
    addVec(0, 0, 0, 16'h0,  16'h0,  0, 0,   0, 0, 3,  0, 0, 0, 0, 1);
    addVec(1, 0, 0, 16'h0,  16'h0,  0, 0,   0, 0, 3,  0, 0, 0, 0, 1);
    addVec(0, 0, 0, 16'h0,  16'h0,  0, 0,   1, 0, 3,  0, 0, 0, 0, 1);
    addVec(0, 1, 0, 16'h1,  16'h0,  1, 0,   1, 0, 3,  1, 0, 0, 0, 0);
    addVec(0, 0, 0, 16'h1,  16'h0,  1, 0,   1, 3, 3,  0, 0, 0, 0, 0);
    addVec(0, 1, 0, 16'h1,  16'h0,  1, 0,   1, 3, 3,  0, 0, 0, 0, 0);
    addVec(0, 0, 0, 16'h0,  16'h0,  0, 0,   1, 3, 3,  0, 0, 0, 0, 0);
    addVec(0, 1, 1, 16'h1,  16'h1,  0, 0,   1, 3, 3,  1, 1, 0, 0, 0);
    addVec(0, 0, 0, 16'h1,  16'h1,  0, 0,   1, 5, 3,  0, 0, 0, 0, 0);
    addVec(0, 0, 0, 16'h1,  16'h1,  0, 0,   1, 5, 3,  0, 0, 0, 0, 0);
    addVec(0, 0, 0, 16'h0,  16'h0,  0, 0,   2, 5, 3,  0, 0, 0, 1, 0);
    addVec(1, 0, 0, 16'h0,  16'h0,  0, 0,   2, 5, 3,  0, 0, 0, 1, 1);
    addVec(0, 0, 0, 16'h0,  16'h0,  0, 0,   0, 5, 3,  0, 0, 0, 1, 1);
    addVec(1, 0, 0, 16'h0,  16'h0,  0, 0,   0, 5, 3,  0, 0, 0, 1, 1);
    addVec(0, 0, 0, 16'h0,  16'h0,  0, 0,   1, 0, 3,  0, 0, 0, 0, 1);
    addVec(0, 0, 0, 16'h0,  16'h1,  0, 0,   1, 0, 3,  0, 0, 0, 0, 0);
    addVec(0, 0, 0, 16'h0,  16'h3,  0, 0,   1, 0, 3,  0, 0, 1, 0, 0);
    addVec(0, 0, 0, 16'h0,  16'h7,  0, 0,   1, 0, 2,  0, 0, 1, 0, 0);
    addVec(0, 0, 0, 16'h0,  16'hF,  0, 0,   1, 0, 1,  0, 0, 1, 0, 0);
    addVec(0, 0, 0, 16'h0,  16'hF,  0, 0,   2, 0, 0,  0, 0, 0, 0, 0);
    addVec(0, 0, 0, 16'h0,  16'hF,  0, 0,   2, 0, 0,  0, 0, 0, 0, 1);
    addVec(1, 0, 0, 16'h0,  16'hF,  0, 0,   2, 0, 0,  0, 0, 0, 0, 1);
    addVec(0, 0, 0, 16'h0,  16'hF,  0, 0,   0, 0, 0,  0, 0, 0, 0, 1);
    addVec(1, 0, 0, 16'h0,  16'hF,  0, 0,   0, 0, 0,  0, 0, 0, 0, 1);
    addVec(0, 0, 0, 16'h0,  16'hF,  0, 0,   1, 0, 3,  0, 0, 0, 0, 1);
    addVec(0, 0, 0, 16'h1,  16'h1E, 0, 0,   1, 0, 3,  0, 0, 1, 0, 0);
    addVec(0, 0, 0, 16'h2,  16'h1E, 0, 0,   1, 0, 2,  0, 0, 1, 0, 0);
    addVec(0, 0, 0, 16'h3,  16'h1F, 0, 0,   1, 0, 1,  0, 0, 0, 0, 0);
    addVec(0, 0, 0, 16'h7,  16'h3F, 0, 0,   1, 0, 1,  0, 0, 1, 0, 0);
    addVec(0, 0, 0, 16'h7,  16'h3F, 0, 0,   2, 0, 0,  0, 0, 0, 0, 0);
    addVec(1, 0, 0, 16'h0,  16'h0,  0, 0,   2, 0, 0,  0, 0, 0, 0, 1);
    addVec(0, 0, 0, 16'h0,  16'h0,  0, 0,   0, 0, 0,  0, 0, 0, 0, 1);
    addVec(1, 0, 0, 16'h0,  16'h0,  0, 0,   0, 0, 0,  0, 0, 0, 0, 1);
    addVec(0, 0, 0, 16'h0,  16'h0,  0, 0,   1, 0, 3,  0, 0, 0, 0, 1);
    addVec(0, 1, 1, 16'h1,  16'h1,  1, 1,   1, 0, 3,  1, 1, 0, 0, 0);
    addVec(0, 0, 0, 16'h3,  16'h3,  1, 1,   1, 6, 3,  0, 0, 0, 0, 0);
    addVec(0, 1, 1, 16'h3,  16'h3,  1, 1,   1, 6, 3,  1, 1, 0, 0, 0);
    addVec(0, 0, 0, 16'h7,  16'h7,  1, 1,   1, 12, 3, 0, 0, 0, 0, 0);
    addVec(0, 1, 1, 16'h7,  16'h7,  1, 1,   1, 12, 3, 1, 1, 0, 0, 0);
    addVec(0, 0, 0, 16'h7,  16'h7,  1, 1,   1, 15, 3, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 16'h7,  16'h7,  1, 1,   1, 15, 3, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 16'h7,  16'h7,  1, 1,   2, 15, 3, 0, 0, 0, 1, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAll("reset", 0, 0, 0, 3, 0, 0, 0, 0, 1);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].st, tbl[i].b1, tbl[i].b2, tbl[i].l1, tbl[i].l2, tbl[i].p1, tbl[i].p2);
      @(negedge clk);
      checkAll("vec", i, tbl[i].gs, tbl[i].sc, tbl[i].lv,
               tbl[i].h1, tbl[i].h2, tbl[i].ms, tbl[i].w, tbl[i].sr);
    end

    // Abort a scoring game by reset with START and BTN1 held through release.
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0);
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0);
    @(negedge clk);
    checkOutput("abort pre gstate", 32'(gstate), 1);
    applyStimulus(0, 1, 0, 16'h1, 16'h0, 16'h1, 16'h0);
    applyStimulus(1, 1, 0, 16'h1, 16'h0, 16'h1, 16'h0);
    #3;
    checkOutput("abort pre score", 32'(score), 3);
    rst_n = 1'b0;
    #1;
    checkAll("abort", 0, 0, 0, 3, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 16'h1 | 16'(i << 1), 16'h0, 16'h1, 16'h0);
      @(negedge clk);
      checkOutput($sformatf("held[%0d] gstate", i), 32'(gstate), 0);
      checkOutput($sformatf("held[%0d] hit1", i), 32'(hit1), 0);
    end

    applyStimulus(0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    modelReset();
    rst_n = 1'b1;
    modelStep("rand", -1);

    n1 = '0; n2 = '0; q1 = '0; q2 = '0;
    for (int i = 0; i < 2500; i++) begin
      ns  = ($urandom_range(0, 7) == 0);
      nb1 = ($urandom_range(0, 1) == 1);
      nb2 = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) begin
        n1 = {($urandom_range(0, 3) == 0), n1[15:1]};
        q1 = {($urandom_range(0, 1) == 1), q1[15:1]};
      end
      if ($urandom_range(0, 2) == 0) begin
        n2 = {($urandom_range(0, 3) == 0), n2[15:1]};
        q2 = {($urandom_range(0, 1) == 1), q2[15:1]};
      end
      if ($urandom_range(0, 199) == 0) n1 = 16'hFFFF;
      if ($urandom_range(0, 199) == 0) n2 = 16'hFFFF;
      applyStimulus(ns, nb1, nb2, n1, n2, q1, q2);
      @(negedge clk);
      modelStep("rand", i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3: lives loaded at game start (1..3).
REQ-002 SHALL have parameter SONG_CYCLES, default 1024: PLAY duration in clocks.
REQ-003 SHALL have parameter SCORE_W, default 10: score width.
REQ-004 SHALL have port CLK  in  1  system clock; all state on rising edge.
REQ-005 SHALL have port RST  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port START  in  1  start/acknowledge button, synchronous, debounced upstream.
REQ-007 SHALL have ports BTN1, BTN2  in  1 each  lane hit buttons, synchronous, debounced upstream.
REQ-008 SHALL have ports LINE1, LINE2  in  16 each  lane note vectors from the shifter; bit 0 is the hit zone.
REQ-009 SHALL have ports PNTS1, PNTS2  in  16 each  lane bonus vectors from the shifter, bit-aligned with LINE1/LINE2.
REQ-010 SHALL have port SHIFT_RST  out  1  active-high reset to the shifter.
REQ-011 SHALL have port SCORE  out  SCORE_W  accumulated score.
REQ-012 SHALL have port LIVES  out  2  remaining lives.
REQ-013 SHALL have port GSTATE  out  2  game state: 00 IDLE, 01 PLAY, 10 OVER.
REQ-014 SHALL have ports HIT1, HIT2, MISS  out  1 each  single-cycle event pulses.
REQ-015 SHALL have port WIN  out  1  valid in OVER; 1 = song completed with lives > 0.

Function
REQ-016 Edge detect SHALL use one registered copy per button; edge = input & ~copy.
REQ-017 FSM SHALL transition IDLE->PLAY on START edge, clearing SCORE, loading LIVES=LIVES_INIT, clearing the cycle counter and WIN.
REQ-018 FSM SHALL transition PLAY->OVER when the cycle counter reaches SONG_CYCLES-1 (WIN=1), or when LIVES becomes 0 (WIN=0); LIVES=0 takes priority if both occur in the same cycle.
REQ-019 FSM SHALL transition OVER->IDLE on START edge; SCORE, LIVES and WIN SHALL hold through OVER and IDLE until the next PLAY entry.
REQ-020 SHIFT_RST SHALL be registered: 1 in IDLE and OVER, 0 from the cycle after PLAY entry.
REQ-021 Per lane, a registered copy of LINEn SHALL be kept; lane "shifted" = LINEn != copy.
REQ-022 Per lane, a consumed flag SHALL be set on a hit and cleared on a shift cycle.
REQ-023 Miss (PLAY only): on a shift cycle, if copy[0]=1 and consumed=0, the lane SHALL register a miss; MISS pulses if either lane misses.
REQ-024 Hit (PLAY only): a BTNn edge with LINEn[0]=1 and consumed (after any same-cycle clear) =0 SHALL pulse HITn and add 1, plus 2 if PNTSn[0]=1.
REQ-025 A BTNn edge with LINEn[0]=0 or an already-consumed note SHALL have no effect.
REQ-026 Both lanes' hits in one cycle SHALL sum; both misses SHALL decrement LIVES by 2; LIVES SHALL saturate at 0.
REQ-027 SCORE SHALL saturate at 2^SCORE_W-1; no wrap.
REQ-028 Event pulses SHALL be 0 outside PLAY; the all-ones unchanged-vector case SHALL be treated as no shift.

Reset
REQ-029 On RST=0 asynchronously: GSTATE=IDLE, SHIFT_RST=1, SCORE=0, LIVES=LIVES_INIT, WIN=0, HIT1/HIT2/MISS=0, counter=0, consumed flags=0, LINE copies=0.
REQ-030 On RST=0, button copies SHALL reset to 1 so that a button held through reset release produces no edge.
REQ-031 Reset asserted mid-PLAY SHALL abort the game immediately, with no OVER state and no WIN.

Verification
REQ-032 Start: IDLE, pulse START 1 cycle -> GSTATE=01, SHIFT_RST=0 the next cycle, LIVES=3, SCORE=0.
REQ-033 Hit with bonus: LINE1[0]=1, PNTS1[0]=1, BTN1 edge -> HIT1 pulse, SCORE 0->3; second BTN1 edge before a shift -> no change.
REQ-034 Misses: three unhit lane-2 notes shift out -> three MISS pulses, LIVES 3->0, GSTATE=OVER, WIN=0, SHIFT_RST=1.
REQ-035 Simultaneous events: both lanes hit in the same cycle (no bonus) -> SCORE+2; both lanes miss with LIVES=1 -> LIVES=0, not wrapped.
REQ-036 Song end: SONG_CYCLES=8, no notes -> OVER after 8 PLAY cycles, WIN=1; START edge -> IDLE with SCORE held.
REQ-037 Async reset: RST low mid-PLAY with BTN1 held -> immediate IDLE reset values; RST released with BTN1 still held -> no HIT1.
